// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational multiplier.
// Operands are captured, held for MUL_CYCLES, and the product is returned through a valid/ready response.

module mult_share_core #(
  parameter int W         = 8,
  parameter int ARCH_TYPE = 2
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);
  generate
    if (ARCH_TYPE == 0) begin : g_shift_add
      always_comb begin
        o_p = '0;
        for (int i = 0; i < W; i++) begin
          if (i_b[i]) o_p = o_p + ({{W{1'b0}}, i_a} << i);
        end
      end
    end else begin : g_native
      assign o_p = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
    end
  endgenerate
endmodule

// Handshake rule for every channel: a transfer happens on the rising edge where valid and
// ready are both high; a producer keeps its payload stable while valid is high and ready is low.
module mult_share_arbiter #(
  parameter int parallelism = 8,
  parameter int ARCH_TYPE   = 2,
  parameter int MUL_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [parallelism-1:0]   req0_a,
  input  logic [parallelism-1:0]   req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [parallelism-1:0]   req1_a,
  input  logic [parallelism-1:0]   req1_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [2*parallelism-1:0] rsp_product,
  output logic                     busy,
  output logic [1:0]               dbg_state
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [parallelism-1:0]   r_op_a;
  logic [parallelism-1:0]   r_op_b;
  logic [CW-1:0]            r_cnt;
  logic                     r_last_grant;
  logic                     r_rsp_id;
  logic                     r_rsp_valid;
  logic [2*parallelism-1:0] r_rsp_product;
  logic [2*parallelism-1:0] w_mul_p;
  logic                     w_pick0;
  logic                     w_pick1;
  logic                     w_accept;

  // On a tie the requester that did not win last time gets the grant.
  assign w_pick0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_pick1 = req1_valid & (~req0_valid | ~r_last_grant);

  assign req0_ready  = rst_n & (r_state == S_IDLE) & w_pick0;
  assign req1_ready  = rst_n & (r_state == S_IDLE) & w_pick1;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

  mult_share_core #(
    .W         (parallelism),
    .ARCH_TYPE (ARCH_TYPE)
  ) u_core (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick0 | w_pick1) begin
          w_state_nxt = S_BUSY;
          w_accept    = 1'b1;
        end
      end
      S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  if (r_rsp_valid & rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The multiplier only ever sees the registered operands, so its output settles while counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_cnt         <= '0;
      r_last_grant  <= 1'b1;
      r_rsp_id      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_product <= '0;
    end else begin
      if (w_accept) begin
        r_op_a       <= w_pick0 ? req0_a : req1_a;
        r_op_b       <= w_pick0 ? req0_b : req1_b;
        r_rsp_id     <= w_pick1;
        r_last_grant <= w_pick1;
        r_cnt        <= CW'(MUL_CYCLES - 1);
      end
      if (r_state == S_BUSY) begin
        if (r_cnt == '0) begin
          r_rsp_product <= w_mul_p;
          r_rsp_valid   <= 1'b1;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
      if ((r_state == S_DONE) && r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: transaction-level model plus directed and random traffic.

module tb_mult_share_arbiter;
  localparam int W  = 8;
  localparam int MC = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_valid = 1'b0, req1_valid = 1'b0;
  logic           req0_ready, req1_ready;
  logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic           rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
  logic [2*W-1:0] rsp_product;
  logic [1:0]     dbg_state;

  mult_share_arbiter #(.parallelism(W), .ARCH_TYPE(2), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  // One operation in flight; its response is visible from MC edges after acceptance until the
  // edge where the consumer takes it. Ties go to the requester that did not win last.
  bit             m_active = 0;
  bit             m_last   = 1;
  bit             m_id     = 0;
  logic [2*W-1:0] m_prod   = '0;
  int             m_acc    = 0;
  int             e        = 0;
  bit             m_was_valid, m_g0, m_g1;
  logic [2*W-1:0] exp_q[$];
  logic           exp_id_q[$];
  logic [2*W-1:0] got_q[$];
  logic           got_id_q[$];
  bit             cmp_en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_last = 1; m_id = 0; m_prod = '0;
      exp_q.delete(); exp_id_q.delete();
    end else begin
      e++;
      m_was_valid = m_active && ((e - 1) >= (m_acc + MC));
      if (m_active) begin
        if (m_was_valid && rsp_ready) begin
          void'(exp_q.pop_front());
          void'(exp_id_q.pop_front());
          m_active = 0;
        end
      end else begin
        m_g0 = req0_valid && (!req1_valid || m_last);
        m_g1 = req1_valid && (!req0_valid || !m_last);
        if (m_g0 || m_g1) begin
          m_active = 1; m_acc = e; m_last = m_g1; m_id = m_g1;
          exp_q.push_back(m_g1 ? (16'(req1_a) * 16'(req1_b)) : (16'(req0_a) * 16'(req0_b)));
          exp_id_q.push_back(m_g1);
        end
      end
      if (m_active && (e == m_acc + MC)) m_prod = exp_q[0];
    end
  end

  // ---------------- compare + scoreboard ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rsp_valid", rsp_valid, m_active && (e >= m_acc + MC));
      check("req0_ready", req0_ready, rst_n && !m_active && req0_valid && (!req1_valid || m_last));
      check("req1_ready", req1_ready, rst_n && !m_active && req1_valid && (!req0_valid || !m_last));
      check("busy", busy, m_active);
      check("rsp_id", rsp_id, m_id);
      check("rsp_product", rsp_product, m_prod);
      if (rsp_valid && rsp_ready) begin
        got_q.push_back(rsp_product);
        got_id_q.push_back(rsp_id);
        if (exp_q.size() > 0) begin
          check("sb_prod", rsp_product, exp_q[0]);
          check("sb_id", rsp_id, exp_id_q[0]);
        end else begin
          check("sb_unexpected", 1, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    got_q.delete(); got_id_q.delete();
  endtask

  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = id ? req1_ready : req0_ready;
      if (!ok) step();
    end
    check("issue_accept", ok, 1);
    step();
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  // Both requesters raised together; records which index was granted first.
  task automatic issue_both(input logic [W-1:0] a0, b0, a1, b1, output int first);
    bit d0 = 0, d1 = 0, a0r, a1r;
    first = -1;
    req0_valid = 1; req0_a = a0; req0_b = b0;
    req1_valid = 1; req1_a = a1; req1_b = b1;
    for (int i = 0; i < 40 && !(d0 && d1); i++) begin
      @(negedge clk);
      a0r = req0_ready; a1r = req1_ready;
      if (first < 0 && a0r) first = 0;
      if (first < 0 && a1r) first = 1;
      step();
      if (a0r) begin req0_valid = 0; d0 = 1; end
      if (a1r) begin req1_valid = 0; d1 = 1; end
    end
    check("both_accepted", d0 && d1, 1);
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 60 && got_q.size() < n; i++) step();
    check("rsp_count_reached", got_q.size() >= n, 1);
  endtask

  // ---------------- stimulus ----------------
  int first;
  int n_acc;
  bit d0, d1;

  initial begin
    // 1: reset held, inputs toggling
    cmp_en = 1;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_product", rsp_product, 0);
      check("rst_busy", busy, 0);
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    rst_n = 1'b1;

    // 2: single op, latency MC
    step();
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h11; rsp_ready = 1;
    @(negedge clk); check("t2_ready_same_cycle", req0_ready, 1);
    step(); req0_valid = 0;
    @(negedge clk); check("t2_busy_after_accept", busy, 1); check("t2_no_rsp_k", rsp_valid, 0);
    @(negedge clk); check("t2_no_rsp_k1", rsp_valid, 0);
    @(negedge clk); check("t2_rsp_k2", rsp_valid, 1);
    check("t2_product", rsp_product, 16'h0121); check("t2_id", rsp_id, 0);
    @(negedge clk); check("t2_idle_after_hs", busy, 0); check("t2_rsp_dropped", rsp_valid, 0);
    check("t2_product_held", rsp_product, 16'h0121);

    // 3: contention and alternation
    do_reset();
    rsp_ready = 1;
    issue_both(8'hFF, 8'hFF, 8'h02, 8'h03, first);
    check("t3_first_grant", first, 0);
    wait_got(2);
    check("t3_rsp0_prod", got_q[0], 16'hFE01); check("t3_rsp0_id", got_id_q[0], 0);
    check("t3_rsp1_prod", got_q[1], 16'h0006); check("t3_rsp1_id", got_id_q[1], 1);
    got_q.delete(); got_id_q.delete();
    issue_both(8'h10, 8'h10, 8'h20, 8'h20, first);
    check("t3_repeat_first_grant", first, 0);
    wait_got(2);
    check("t3_rep0_prod", got_q[0], 16'h0100); check("t3_rep1_prod", got_q[1], 16'h0400);

    // 4: backpressure in DONE
    got_q.delete(); got_id_q.delete();
    rsp_ready = 0;
    issue(0, 8'h03, 8'h04);
    req1_valid = 1; req1_a = 8'h07; req1_b = 8'h08;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    check("t4_rsp_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_prod", rsp_product, 16'h000C);
      check("t4_hold_id", rsp_id, 0);
      check("t4_no_ready0", req0_ready, 0);
      check("t4_no_ready1", req1_ready, 0);
    end
    step(); rsp_ready = 1;
    d1 = 0;
    for (int i = 0; i < 10 && !d1; i++) begin @(negedge clk); d1 = req1_ready; if (!d1) step(); end
    check("t4_req1_granted_after_hs", d1, 1);
    step(); req1_valid = 0;
    wait_got(2);
    check("t4_rsp0", got_q[0], 16'h000C);
    check("t4_rsp1", got_q[1], 16'h0038); check("t4_rsp1_id", got_id_q[1], 1);

    // 5: reset during BUSY
    got_q.delete(); got_id_q.delete();
    issue(0, 8'h05, 8'h05);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", rsp_valid, 0); check("t5_rst_busy", busy, 0);
    check("t5_rst_prod", rsp_product, 0); check("t5_rst_id", rsp_id, 0);
    step(); step();
    rst_n = 1'b1;
    issue(1, 8'h00, 8'hFF);
    wait_got(1);
    for (int i = 0; i < 10; i++) step();
    check("t5_one_rsp", got_q.size(), 1);
    check("t5_prod", got_q[0], 16'h0000); check("t5_id", got_id_q[0], 1);

    // 6: random traffic with random backpressure
    got_q.delete(); got_id_q.delete();
    n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      d0 = req0_valid && req0_ready; d1 = req1_valid && req1_ready;
      n_acc += int'(d0) + int'(d1);
      step();
      if (d0) req0_valid = 0;
      if (d1) req1_valid = 0;
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1; req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1; req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
      end
      rsp_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    n_acc += int'(req0_valid && req0_ready) + int'(req1_valid && req1_ready);
    step();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    check("t6_drained", exp_q.size(), 0);
    check("t6_idle", busy, 0);
    check("t6_rsp_count", got_q.size(), n_acc);
    check("t6_enough_ops", n_acc > 300, 1);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
